uart_fifo: RTL and testbench

UART_FIFO -- requirements
Module: uart_fifo

---
 rtl/uart_fifo_if.sv | 20 ++
 rtl/uart_fifo.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_if.sv
// Register bus of uart_fifo: write/read strobes, 2-bit address, write data,
// combinational read data and the RX interrupt.
interface uart_fifo_if;
    logic       writeEnable;
    logic       readEnable;
    logic [1:0] regSelect;
    logic [7:0] writeData;
    logic [7:0] Data;
    logic       irq;

    modport master (
        output writeEnable, readEnable, regSelect, writeData,
        input  Data, irq
    );

    modport slave (
        input  writeEnable, readEnable, regSelect, writeData,
        output Data, irq
    );
endinterface

// File: rtl/uart_fifo.sv
// UART with TX/RX FIFOs and a 4-register bus (data, status, control, reserved).
// Define UART_FIFO_PARITY_EN to add an even parity bit to every frame.
//
// state    | meaning (TX and RX machines)
// S_IDLE   | line idle, waiting for FIFO data (TX) or a falling edge (RX)
// S_START  | start bit
// S_DATA   | data bits, LSB first
// S_PARITY | even parity bit (UART_FIFO_PARITY_EN only)
// S_STOP   | stop bit
module uart_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int DIVISOR    = 208,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    uart_fifo_if.slave  bus,
    input  logic        rx,
    output logic        tx
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(DIVISOR);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_TC   = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_FIFO_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [2:0] ctrl;
    logic       tx_ovf, par_err, frm_err, rx_ovr;
    logic [7:0] status;

    logic wr_data, wr_stat, wr_ctrl, rd_pop;

    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [PTR_W:0]       tx_wr_ptr, tx_rd_ptr;
    logic                 tx_empty, tx_full, tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [PTR_W:0]       rx_wr_ptr, rx_rd_ptr;
    logic                 rx_empty, rx_full, rx_push;
    logic [DATA_BITS-1:0] rx_head;

    state_t               tx_state, tx_state_n;
    logic [CNT_W-1:0]     tx_cnt, tx_cnt_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic [BIT_W-1:0]     tx_bit, tx_bit_n;
    logic                 tx_q, tx_line_n, tx_tc;

    logic                 rx_meta, rx_sync, rx_prev, rx_fall;
    state_t               rx_state, rx_state_n;
    logic [CNT_W-1:0]     rx_cnt, rx_cnt_n;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
    logic [BIT_W-1:0]     rx_bit, rx_bit_n;
    logic                 rx_tc, rx_done, frm_set, par_set, ovr_set;

    assign wr_data = bus.writeEnable && (bus.regSelect == 2'b00);
    assign wr_stat = bus.writeEnable && (bus.regSelect == 2'b01);
    assign wr_ctrl = bus.writeEnable && (bus.regSelect == 2'b10);
    assign rd_pop  = bus.readEnable  && (bus.regSelect == 2'b00) && !rx_empty;

    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full  = (tx_wr_ptr[PTR_W] != tx_rd_ptr[PTR_W]) &&
                      (tx_wr_ptr[PTR_W-1:0] == tx_rd_ptr[PTR_W-1:0]);
    assign tx_head  = tx_mem[tx_rd_ptr[PTR_W-1:0]];
    // A write to a full FIFO still lands if the transmitter frees a slot this cycle.
    assign tx_push  = wr_data && (!tx_full || tx_pop);

    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full  = (rx_wr_ptr[PTR_W] != rx_rd_ptr[PTR_W]) &&
                      (rx_wr_ptr[PTR_W-1:0] == rx_rd_ptr[PTR_W-1:0]);
    assign rx_head  = rx_mem[rx_rd_ptr[PTR_W-1:0]];
    assign rx_push  = rx_done && (!rx_full || rd_pop);
    assign ovr_set  = rx_done && !rx_push;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr[PTR_W-1:0]] <= bus.writeData[DATA_BITS-1:0];
        if (rx_push) rx_mem[rx_wr_ptr[PTR_W-1:0]] <= rx_shift_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rd_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
        end
    end

    // Sticky flags: a new event in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl    <= '0;
            tx_ovf  <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            rx_ovr  <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= bus.writeData[2:0];
            tx_ovf  <= (tx_ovf  && !(wr_stat && bus.writeData[7])) || (wr_data && !tx_push);
            par_err <= (par_err && !(wr_stat && bus.writeData[6])) || par_set;
            frm_err <= (frm_err && !(wr_stat && bus.writeData[5])) || frm_set;
            rx_ovr  <= (rx_ovr  && !(wr_stat && bus.writeData[4])) || ovr_set;
        end
    end

    assign status = {tx_ovf, par_err, frm_err, rx_ovr, !rx_empty, tx_empty, tx_full,
                     tx_state != S_IDLE};

    always_comb begin
        case (bus.regSelect)
            2'b00:   bus.Data = rx_empty ? 8'h00 : 8'(rx_head);
            2'b01:   bus.Data = status;
            2'b10:   bus.Data = {5'b0, ctrl};
            default: bus.Data = 8'h00;
        endcase
    end

    assign bus.irq = ctrl[2] && !rx_empty;
    assign tx      = tx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
            tx_q     <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_shift <= tx_shift_n;
            tx_bit   <= tx_bit_n;
            tx_q     <= tx_line_n;
        end
    end

    // tx is registered from the next-state decode so the line moves with the state.
    always_comb begin
        tx_tc      = (tx_cnt == '0);
        tx_state_n = tx_state;
        tx_cnt_n   = tx_tc ? '0 : tx_cnt - 1'b1;
        tx_shift_n = tx_shift;
        tx_bit_n   = tx_bit;
        tx_line_n  = tx_q;
        tx_pop     = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_line_n = 1'b1;
                if (!tx_empty && ctrl[0]) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_cnt_n   = BIT_TC;
                    tx_line_n  = 1'b0;
                    tx_state_n = S_START;
                end
            end
            S_START: begin
                if (tx_tc) begin
                    tx_state_n = S_DATA;
                    tx_cnt_n   = BIT_TC;
                    tx_bit_n   = '0;
                    tx_line_n  = tx_shift[0];
                end
            end
            S_DATA: begin
                if (tx_tc) begin
                    tx_cnt_n = BIT_TC;
                    if (tx_bit == LAST_BIT) begin
`ifdef UART_FIFO_PARITY_EN
                        tx_state_n = S_PARITY;
                        tx_line_n  = ^tx_shift;
`else
                        tx_state_n = S_STOP;
                        tx_line_n  = 1'b1;
`endif
                    end else begin
                        tx_bit_n  = tx_bit + 1'b1;
                        tx_line_n = tx_shift[tx_bit_n];
                    end
                end
            end
`ifdef UART_FIFO_PARITY_EN
            S_PARITY: begin
                if (tx_tc) begin
                    tx_state_n = S_STOP;
                    tx_cnt_n   = BIT_TC;
                    tx_line_n  = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (tx_tc) begin
                    if (!tx_empty && ctrl[0]) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = tx_head;
                        tx_cnt_n   = BIT_TC;
                        tx_line_n  = 1'b0;
                        tx_state_n = S_START;
                    end else begin
                        tx_line_n  = 1'b1;
                        tx_state_n = S_IDLE;
                    end
                end
            end
            default: begin
                tx_line_n  = 1'b1;
                tx_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_bit   <= '0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_shift <= rx_shift_n;
            rx_bit   <= rx_bit_n;
        end
    end

    // A new start needs a high-to-low edge, so after a bad stop bit the line must recover first.
    assign rx_fall = rx_prev && !rx_sync;

    always_comb begin
        rx_tc      = (rx_cnt == '0);
        rx_state_n = rx_state;
        rx_cnt_n   = rx_tc ? '0 : rx_cnt - 1'b1;
        rx_shift_n = rx_shift;
        rx_bit_n   = rx_bit;
        rx_done    = 1'b0;
        frm_set    = 1'b0;
        par_set    = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (rx_fall && ctrl[1]) begin
                    rx_state_n = S_START;
                    rx_cnt_n   = HALF_TC;
                end
            end
            S_START: begin
                if (rx_tc) begin
                    if (rx_sync) begin
                        rx_state_n = S_IDLE;
                    end else begin
                        rx_state_n = S_DATA;
                        rx_cnt_n   = BIT_TC;
                        rx_bit_n   = '0;
                    end
                end
            end
            S_DATA: begin
                if (rx_tc) begin
                    rx_shift_n = {rx_sync, rx_shift[DATA_BITS-1:1]};
                    rx_cnt_n   = BIT_TC;
                    if (rx_bit == LAST_BIT) begin
`ifdef UART_FIFO_PARITY_EN
                        rx_state_n = S_PARITY;
`else
                        rx_state_n = S_STOP;
`endif
                    end else begin
                        rx_bit_n = rx_bit + 1'b1;
                    end
                end
            end
`ifdef UART_FIFO_PARITY_EN
            S_PARITY: begin
                if (rx_tc) begin
                    par_set    = (rx_sync != ^rx_shift);
                    rx_state_n = S_STOP;
                    rx_cnt_n   = BIT_TC;
                end
            end
`endif
            S_STOP: begin
                if (rx_tc) begin
                    rx_state_n = S_IDLE;
                    rx_done    = rx_sync;
                    frm_set    = !rx_sync;
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo at DIVISOR=16, FIFO_DEPTH=4: register table plus
// hand-written TX/RX frame sequences.
`timescale 1ns/1ps
module tb_uart_fifo;
    localparam int DIV = 16;
`ifdef UART_FIFO_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic tx;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_fifo_if bus();

    uart_fifo #(.DATA_BITS(8), .DIVISOR(DIV), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .rx    (rx),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       we;
        logic [1:0] waddr;
        logic [7:0] wdata;
        logic [1:0] raddr;
        logic [7:0] exp_data;
        logic       exp_irq;
        string      name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] d);
        @(negedge clk);
        bus.writeEnable = 1'b1;
        bus.regSelect   = addr;
        bus.writeData   = d;
        @(negedge clk);
        bus.writeEnable = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] addr, input logic [7:0] exp);
        @(negedge clk);
        bus.regSelect = addr;
        #1;
        check(name, bus.Data, exp);
    endtask

    task automatic pop();
        @(negedge clk);
        bus.regSelect  = 2'b00;
        bus.readEnable = 1'b1;
        @(negedge clk);
        bus.readEnable = 1'b0;
    endtask

    task automatic wait_tx_fall(input int limit, output int n, output bit got);
        n = 0;
        got = 1'b0;
        while (n < limit) begin
            @(posedge clk);
            #1;
            n++;
            if (tx == 1'b0) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // Samples each bit 7 cycles after it begins; bits[0] is the start bit.
    task automatic capture_frame(input int limit, output logic [15:0] bits, output int gap,
                                 output bit got);
        bits = '0;
        wait_tx_fall(limit, gap, got);
        if (got) begin
            repeat (7) @(posedge clk);
            #1;
            bits[0] = tx;
            for (int k = 1; k < NB; k++) begin
                repeat (DIV) @(posedge clk);
                #1;
                bits[k] = tx;
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop_b, input logic par_flip);
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef UART_FIFO_PARITY_EN
        rx = (^d) ^ par_flip;
        repeat (DIV) @(negedge clk);
`endif
        rx = stop_b;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
    endtask

    vec_t        vecs [10];
    logic [15:0] bits;
    int          gap;
    bit          got;
    int          lows;
    logic [7:0]  tx_bytes [4];

    initial begin
        vecs[0] = '{1'b0, 2'b00, 8'h00, 2'b01, 8'h04, 1'b0, "rst_status"};
        vecs[1] = '{1'b0, 2'b00, 8'h00, 2'b10, 8'h00, 1'b0, "rst_ctrl"};
        vecs[2] = '{1'b0, 2'b00, 8'h00, 2'b00, 8'h00, 1'b0, "rst_data"};
        vecs[3] = '{1'b0, 2'b00, 8'h00, 2'b11, 8'h00, 1'b0, "rst_rsvd"};
        vecs[4] = '{1'b1, 2'b10, 8'hFF, 2'b10, 8'h07, 1'b0, "ctrl_mask"};
        vecs[5] = '{1'b1, 2'b11, 8'hFF, 2'b11, 8'h00, 1'b0, "rsvd_reads_zero"};
        vecs[6] = '{1'b1, 2'b11, 8'h00, 2'b10, 8'h07, 1'b0, "rsvd_no_alias"};
        vecs[7] = '{1'b1, 2'b01, 8'hFF, 2'b01, 8'h04, 1'b0, "stat_clear_noop"};
        vecs[8] = '{1'b0, 2'b00, 8'h00, 2'b00, 8'h00, 1'b0, "data_empty"};
        vecs[9] = '{1'b1, 2'b10, 8'h00, 2'b10, 8'h00, 1'b0, "ctrl_clear"};
        tx_bytes = '{8'hA1, 8'h3C, 8'hFF, 8'h00};

        bus.writeEnable = 1'b0;
        bus.readEnable  = 1'b0;
        bus.regSelect   = 2'b00;
        bus.writeData   = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx_high", tx, 1'b1);
        check("rst_irq", bus.irq, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].we) wr(vecs[i].waddr, vecs[i].wdata);
            rd_chk(vecs[i].name, vecs[i].raddr, vecs[i].exp_data);
            check({vecs[i].name, "_irq"}, bus.irq, vecs[i].exp_irq);
        end

        pop();
        rd_chk("pop_empty_status", 2'b01, 8'h04);

        // Single TX frame 0x55: start length, data LSB first, stop, busy flag.
        wr(2'b00, 8'h55);
        wr(2'b10, 8'h01);
        bus.regSelect = 2'b01;
        wait_tx_fall(50, gap, got);
        check("tx55_start_seen", got, 1'b1);
        lows = 1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (tx != 1'b0) break;
            lows++;
        end
        check("tx55_start_len", lows, DIV);
        bits = '0;
        repeat (7) @(posedge clk);
        #1;
        bits[0] = tx;
        check("tx55_busy", bus.Data[0], 1'b1);
        for (int k = 1; k < NB - 1; k++) begin
            repeat (DIV) @(posedge clk);
            #1;
            bits[k] = tx;
        end
        check("tx55_data", bits[7:0], 8'h55);
        check("tx55_stop", bits[NB-2], 1'b1);
        repeat (30) @(posedge clk);
        rd_chk("tx55_done_status", 2'b01, 8'h04);

        // Fill TX FIFO while disabled, overflow, then four back-to-back frames.
        wr(2'b10, 8'h00);
        wr(2'b00, 8'hA1);
        wr(2'b00, 8'h3C);
        wr(2'b00, 8'hFF);
        wr(2'b00, 8'h00);
        wr(2'b00, 8'h77);
        rd_chk("txfull_status", 2'b01, 8'h82);
        wr(2'b10, 8'h01);
        for (int f = 0; f < 4; f++) begin
            capture_frame(60, bits, gap, got);
            check($sformatf("b2b_frame%0d_seen", f), got, 1'b1);
            check($sformatf("b2b_frame%0d_data", f), bits[8:1], tx_bytes[f]);
            check($sformatf("b2b_frame%0d_stop", f), bits[NB-1], 1'b1);
            if (f > 0) check($sformatf("b2b_frame%0d_gap", f), gap, 9);
        end
        wait_tx_fall(300, gap, got);
        check("tx_fifth_absent", got, 1'b0);
        rd_chk("tx_drained_status", 2'b01, 8'h84);
        wr(2'b01, 8'h80);
        rd_chk("tx_ovf_cleared", 2'b01, 8'h04);

        // RX byte, interrupt, pop.
        wr(2'b10, 8'h06);
        send_rx(8'hC3, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        rd_chk("rxC3_status", 2'b01, 8'h0C);
        check("rxC3_irq", bus.irq, 1'b1);
        rd_chk("rxC3_data", 2'b00, 8'hC3);
        pop();
        rd_chk("rxC3_popped_status", 2'b01, 8'h04);
        check("rxC3_popped_irq", bus.irq, 1'b0);
        rd_chk("rxC3_popped_data", 2'b00, 8'h00);

        // Glitch rejection, framing error, recovery.
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        rd_chk("glitch_status", 2'b01, 8'h04);
        send_rx(8'h5A, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        rd_chk("frame_err_status", 2'b01, 8'h24);
        rd_chk("frame_err_data", 2'b00, 8'h00);
        wr(2'b01, 8'h20);
        rd_chk("frame_err_cleared", 2'b01, 8'h04);
        send_rx(8'h81, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        rd_chk("recover_data", 2'b00, 8'h81);
        pop();

`ifdef UART_FIFO_PARITY_EN
        send_rx(8'h03, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        rd_chk("rx_par_status", 2'b01, 8'h4C);
        rd_chk("rx_par_data", 2'b00, 8'h03);
        pop();
        wr(2'b01, 8'h40);
        rd_chk("rx_par_cleared", 2'b01, 8'h04);
        wr(2'b00, 8'h07);
        wr(2'b10, 8'h07);
        capture_frame(60, bits, gap, got);
        check("tx_par_seen", got, 1'b1);
        check("tx_par_data", bits[8:1], 8'h07);
        check("tx_par_bit", bits[9], 1'b1);
        check("tx_par_stop", bits[10], 1'b1);
        repeat (30) @(negedge clk);
        wr(2'b10, 8'h06);
`endif

        // Five frames without popping: four stored, overrun; then reset mid-frame.
        send_rx(8'h11, 1'b1, 1'b0);
        send_rx(8'h22, 1'b1, 1'b0);
        send_rx(8'h33, 1'b1, 1'b0);
        send_rx(8'h44, 1'b1, 1'b0);
        send_rx(8'h55, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        rd_chk("overrun_status", 2'b01, 8'h1C);
        rd_chk("overrun_head", 2'b00, 8'h11);
        wr(2'b00, 8'h00);
        wr(2'b10, 8'h07);
        repeat (5) @(negedge clk);
        check("pre_reset_tx_low", tx, 1'b0);
        check("pre_reset_irq", bus.irq, 1'b1);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_tx_high", tx, 1'b1);
        check("reset_irq", bus.irq, 1'b0);
        rd_chk("reset_status", 2'b01, 8'h04);
        rd_chk("reset_data", 2'b00, 8'h00);
        rd_chk("reset_ctrl", 2'b10, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        rd_chk("post_reset_status", 2'b01, 8'h04);
        check("post_reset_tx", tx, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
